sha256_iter_core: RTL

//  Iterative multi-block SHA-256 compression engine with valid/ready block input.

---
 rtl/sha256_iter_core.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/sha256_iter_core.sv
// Iterative SHA-256 block engine, RPC rounds per clock, hash chained across blocks (SHA-224 via SHA256_SHA224_EN).
// Latency: accept -> hash_valid after 64/RPC+1 cycles; blk_ready only in IDLE, so blocks are held off while busy.
module sha256_iter_core #(
    parameter int RPC = 4
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic         blk_first,
    input  logic [511:0] blk_data,
`ifdef SHA256_SHA224_EN
    input  logic         mode224,
`endif
    output logic         hash_valid,
    output logic [255:0] hash,
    output logic         busy
);

    typedef logic [7:0][31:0]  word8_t;
    typedef logic [15:0][31:0] word16_t;
    typedef enum logic [1:0] {IDLE, RUN, FINAL} state_t;

    if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8 || RPC == 16)) begin : g_rpc_check
        $error("sha256_iter_core: RPC must be 1, 2, 4, 8 or 16");
    end

    localparam logic [5:0] LAST_RND = 6'(64 - RPC);
    localparam word8_t IV256 = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Word 0 of the window is W[rnd]; RPC rounds consume window words 0..RPC-1.
    function automatic word8_t do_rounds(input word8_t v, input word16_t w, input logic [5:0] rnd);
        word8_t      r;
        logic [31:0] t1;
        logic [31:0] t2;
        r = v;
        for (int i = 0; i < RPC; i++) begin
            t1 = r[7] + K[rnd + 6'(i)] + w[i] + ((r[4] & r[5]) ^ (~r[4] & r[6])) + big_s1(r[4]);
            t2 = big_s0(r[0]) + ((r[0] & r[1]) ^ (r[0] & r[2]) ^ (r[1] & r[2]));
            r  = {r[6:4], r[3] + t1, r[2:0], t1 + t2};
        end
        return r;
    endfunction

    function automatic word16_t next_sched(input word16_t w);
        logic [31:0] ext [0:31];
        word16_t     r;
        for (int j = 0; j < 16; j++) ext[j] = w[j];
        for (int j = 16; j < 16 + RPC; j++)
            ext[j] = small_s1(ext[j-2]) + ext[j-7] + small_s0(ext[j-15]) + ext[j-16];
        for (int j = 0; j < 16; j++) r[j] = ext[j+RPC];
        return r;
    endfunction

    state_t     state, next_state;
    logic [5:0] rnd_q;
    word16_t    w_q;
    word8_t     v_q, h_q, hbase, sum, hash_new, iv_acc, iv_msg;
    logic [255:0] hash_q;
    logic       first_q;

`ifdef SHA256_SHA224_EN
    localparam word8_t IV224 = {32'hbefa4fa4, 32'h64f98fa7, 32'h68581511, 32'hffc00b31,
                                32'hf70e5939, 32'h3070dd17, 32'h367cd507, 32'hc1059ed8};
    logic mode_q;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset)                                     mode_q <= 1'b0;
        else if (state == IDLE && blk_valid && blk_first) mode_q <= mode224;
    end

    assign iv_acc = mode224 ? IV224 : IV256;
    assign iv_msg = mode_q  ? IV224 : IV256;
`else
    assign iv_acc = IV256;
    assign iv_msg = IV256;
`endif

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (blk_valid) next_state = RUN;
            RUN:     if (rnd_q == LAST_RND) next_state = FINAL;
            FINAL:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        hbase = first_q ? iv_msg : h_q;
        for (int j = 0; j < 8; j++) sum[j] = hbase[j] + v_q[j];
        hash_new = sum;
`ifdef SHA256_SHA224_EN
        if (mode_q) hash_new[7] = '0;
`endif
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            rnd_q   <= '0;
            w_q     <= '0;
            v_q     <= '0;
            h_q     <= IV256;
            hash_q  <= '0;
            first_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (blk_valid) begin
                    w_q     <= blk_data;
                    v_q     <= blk_first ? iv_acc : h_q;
                    first_q <= blk_first;
                    rnd_q   <= '0;
                end
                RUN: begin
                    w_q   <= next_sched(w_q);
                    v_q   <= do_rounds(v_q, w_q, rnd_q);
                    rnd_q <= rnd_q + 6'(RPC);
                end
                FINAL: begin
                    h_q    <= sum;
                    hash_q <= hash_new;
                end
                default: ;
            endcase
        end
    end

    // The new digest is presented during the hash_valid cycle itself and held afterwards.
    assign blk_ready  = (state == IDLE);
    assign busy       = (state == RUN) || (state == FINAL);
    assign hash_valid = (state == FINAL);
    assign hash       = hash_valid ? hash_new : hash_q;

endmodule
